// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I multicycle control unit.
// Opcodes, funct fields, ALU codes, mux selects and FSM state codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLL = 3'd3;
  localparam logic [2:0] ALU_NE  = 3'd4;

  localparam logic [1:0] SA_PC    = 2'd0;
  localparam logic [1:0] SA_OLDPC = 2'd1;
  localparam logic [1:0] SA_RS1   = 2'd2;

  localparam logic [1:0] SB_RS2  = 2'd0;
  localparam logic [1:0] SB_IMM  = 2'd1;
  localparam logic [1:0] SB_FOUR = 2'd2;

  localparam logic [1:0] RS_ALUOUT = 2'd0;
  localparam logic [1:0] RS_MEM    = 2'd1;
  localparam logic [1:0] RS_ALUY   = 2'd2;

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

endpackage

// File: rtl/riscv_mc_control_alu_dec.sv
// R-type funct3/funct7 decoder: ALU operation plus legality bit.
// Shared by the DECODE legality check and the EXEC_R ALU select.
module riscv_alu_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    unique case (1'b1)
      (funct3 == F3_ADD && funct7 == F7_BASE): begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
      end
      (funct3 == F3_ADD && funct7 == F7_ALT): begin
        alu_ctrl = ALU_SUB;
        legal    = 1'b1;
      end
      (funct3 == F3_XOR && funct7 == F7_BASE): begin
        alu_ctrl = ALU_XOR;
        legal    = 1'b1;
      end
      (funct3 == F3_SLL && funct7 == F7_BASE): begin
        alu_ctrl = ALU_SLL;
        legal    = 1'b1;
      end
      default: begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle control FSM for the RV32I subset datapath.
// Optional retired-instruction counter enabled by RV_CTRL_INSTRET_EN.
module riscv_mc_control
  import riscv_ctrl_pkg::*;
#(
  parameter bit RESET_TO_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        adr_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        illegal,
  output logic [31:0] instret
);

  logic [3:0] state;
  logic [3:0] nxt;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [2:0] r_ctrl;
  logic       r_legal;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  riscv_alu_dec u_dec (
    .funct3   (f3),
    .funct7   (f7),
    .alu_ctrl (r_ctrl),
    .legal    (r_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_RESET:
        if (RESET_TO_FETCH || start) nxt = S_FETCH;
      S_FETCH:
        if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        nxt = S_TRAP;
        unique case (1'b1)
          (opcode == OP_R):
            nxt = r_legal ? S_EXEC_R : S_TRAP;
          (opcode == OP_I):
            nxt = (f3 == F3_ADD) ? S_EXEC_I : S_TRAP;
          (opcode == OP_LOAD),
          (opcode == OP_STORE):
            nxt = (f3 == F3_W) ? S_MEM_ADDR : S_TRAP;
          (opcode == OP_BR):
            nxt = (f3 == F3_BNE) ? S_BRANCH : S_TRAP;
          default:
            nxt = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I:
        nxt = S_WB_ALU;
      S_MEM_ADDR:
        nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        if (mem_ready) nxt = S_WB_MEM;
      S_MEM_WR:
        if (mem_ready) nxt = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH:
        nxt = S_FETCH;
      S_TRAP:
        nxt = S_TRAP;
      default:
        nxt = S_RESET;
    endcase
  end

  always_comb begin
    alu_ctrl   = ALU_ADD;
    alu_src_a  = SA_PC;
    alu_src_b  = SB_RS2;
    result_src = RS_ALUOUT;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SB_FOUR;
        result_src = RS_ALUY;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SA_OLDPC;
        alu_src_b = SB_IMM;
      end
      S_EXEC_R: begin
        alu_src_a = SA_RS1;
        alu_ctrl  = r_ctrl;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = SA_RS1;
        alu_src_b = SB_IMM;
      end
      S_WB_ALU:
        reg_write = 1'b1;
      S_MEM_RD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
      end
      S_WB_MEM: begin
        result_src = RS_MEM;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SA_RS1;
        alu_ctrl  = ALU_NE;
        pc_write  = ~zero;
      end
      S_TRAP:
        illegal = 1'b1;
      default: ;
    endcase
  end

`ifdef RV_CTRL_INSTRET_EN
  logic [31:0] cnt;
  logic        retire;

  // Counts completions only; RESET->FETCH is not a retirement.
  assign retire = (state == S_WB_ALU) || (state == S_WB_MEM) ||
                  (state == S_BRANCH) ||
                  (state == S_MEM_WR && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (retire) cnt <= cnt + 32'd1;
  end

  assign instret = cnt;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed scoreboard bench for riscv_mc_control.
// Expected output vectors are queued per step and popped at negedge.
module tb_riscv_mc_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  alu_ctrl;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic        adr_src;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        illegal;
  logic [31:0] instret;

  typedef struct {
    string       tag;
    logic [15:0] vec;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ret = 0;

`ifdef RV_CTRL_INSTRET_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  riscv_mc_control #(.RESET_TO_FETCH(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .instr      (instr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_ctrl   (alu_ctrl),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .adr_src    (adr_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ov(
    input logic [2:0] alu, input logic [1:0] sa,
    input logic [1:0] sb_, input logic [1:0] rs,
    input logic adr, input logic mr, input logic mw,
    input logic irw, input logic pcw, input logic rw,
    input logic ill);
    return {alu, sa, sb_, rs, adr, mr, mw, irw, pcw, rw, ill};
  endfunction

  function automatic logic [15:0] obs();
    return {alu_ctrl, alu_src_a, alu_src_b, result_src, adr_src,
            mem_read, mem_write, ir_write, pc_write, reg_write, illegal};
  endfunction

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.vec = v;
    e.ret = CNT_EN ? exp_ret : 32'd0;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    logic [15:0] o;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    o = obs();
    checks++;
    assert (o === e.vec) else begin
      errors++;
      $error("FAIL %s outputs observed=%h expected=%h", e.tag, o, e.vec);
    end
    checks++;
    assert (instret === e.ret) else begin
      errors++;
      $error("FAIL %s instret observed=%0d expected=%0d",
             e.tag, instret, e.ret);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] v,
                      input bit retire);
    push(tag, v);
    @(negedge clk);
    pop_check();
    if (retire) exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_now(input string tag);
    rst_n = 1'b0;
    #1;
    exp_ret = 0;
    push(tag, 16'h0);
    pop_check();
  endtask

  localparam logic [15:0] V_FETCH  = ov(0, 0, 2, 2, 0, 1, 0, 1, 1, 0, 0);
  localparam logic [15:0] V_FWAIT  = ov(0, 0, 2, 2, 0, 1, 0, 0, 0, 0, 0);
  localparam logic [15:0] V_DECODE = ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [15:0] V_EXEC_I = ov(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [15:0] V_WB_ALU = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  localparam logic [15:0] V_MEMRD  = ov(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
  localparam logic [15:0] V_WB_MEM = ov(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
  localparam logic [15:0] V_MEMWR  = ov(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
  localparam logic [15:0] V_TRAP   = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

  task automatic fetch_decode(input logic [31:0] ins);
    instr     = ins;
    mem_ready = 1'b1;
    step("fetch", V_FETCH, 0);
    step("decode", V_DECODE, 0);
  endtask

  task automatic run_r(input logic [31:0] ins, input logic [2:0] alu,
                       input string tag);
    fetch_decode(ins);
    step(tag, ov(alu, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step("wb_alu", V_WB_ALU, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    instr     = 32'h0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #1;
    push("reset_low", 16'h0);
    pop_check();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("reset", 16'h0, 0);

    run_r(32'h0020_8033, 3'd0, "exec_add");
    run_r(32'h4020_8033, 3'd1, "exec_sub");
    run_r(32'h0020_C033, 3'd2, "exec_xor");
    run_r(32'h0020_9033, 3'd3, "exec_sll");

    fetch_decode(32'h0010_8093);
    step("exec_addi", V_EXEC_I, 0);
    step("wb_addi", V_WB_ALU, 1);

    instr     = 32'h0000_A083;
    mem_ready = 1'b0;
    step("fetch_wait", V_FWAIT, 0);
    fetch_decode(32'h0000_A083);
    step("lw_addr", V_EXEC_I, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw_wait", V_MEMRD, 0);
    mem_ready = 1'b1;
    step("lw_done", V_MEMRD, 0);
    step("wb_mem", V_WB_MEM, 1);

    fetch_decode(32'h0020_A023);
    step("sw_addr", V_EXEC_I, 0);
    step("sw_done", V_MEMWR, 1);

    fetch_decode(32'h0020_9463);
    zero = 1'b0;
    step("bne_taken", ov(4, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1);
    fetch_decode(32'h0020_9463);
    zero = 1'b1;
    step("bne_not", ov(4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    zero = 1'b0;

    fetch_decode(32'h0000_0073);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      step("trap", V_TRAP, 0);
    end
    rst_now("trap_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("reset2", 16'h0, 0);

    fetch_decode(32'h6020_8033);
    step("bad_f7", V_TRAP, 0);
    rst_now("bad_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("reset3", 16'h0, 0);

    fetch_decode(32'h0020_A023);
    step("sw_addr2", V_EXEC_I, 0);
    mem_ready = 1'b0;
    step("sw_wait", V_MEMWR, 0);
    step("sw_wait", V_MEMWR, 0);
    push("sw_hold", V_MEMWR);
    pop_check();
    rst_now("sw_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mc_control.md
Name: riscv_mc_control

Overview:
Multicycle control unit for the RV32I subset datapath: ADD, SUB, XOR, SLL, ADDI, LW, SW, BNE.
- Drives the ALU from the opposite side of its interface: it sources alu_ctrl and consumes the ALU zero flag.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Handshakes with a shared instruction/data memory via mem_ready.
- Sits between the IR/datapath muxes and the ALU/register file/memory.

Parameters:
- RESET_TO_FETCH, 1, 1: leave RESET one cycle after reset deasserts; 0: hold in RESET until start pulses.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  leave RESET when RESET_TO_FETCH=0; ignored otherwise
- instr  input  32  current IR contents
- zero  input  1  ALU zero flag (Y==0)
- mem_ready  input  1  memory completes current request this cycle
- alu_ctrl  output  3  0 ADD, 1 SUB, 2 XOR, 3 SLL, 4 NE (Y=1 when A!=B)
- alu_src_a  output  2  0 PC, 1 old PC, 2 rs1 register
- alu_src_b  output  2  0 rs2 register, 1 immediate, 2 constant 4
- result_src  output  2  0 ALUOut register, 1 memory data, 2 ALU Y direct
- adr_src  output  1  0 PC, 1 ALUOut
- mem_read  output  1  read request, held until mem_ready
- mem_write  output  1  write request, held until mem_ready
- ir_write  output  1  latch IR and old PC
- pc_write  output  1  load PC from result mux
- reg_write  output  1  write rd
- illegal  output  1  sticky illegal-instruction flag
- instret  output  32  retired-instruction count (optional feature)

Behaviour:
- Async reset: state RESET; all outputs 0, including illegal and instret.
- All outputs are decoded from state. ir_write and pc_write in FETCH, and pc_write in BRANCH, are additionally gated as stated below. Unlisted outputs are 0.
- RESET → FETCH:
  - RESET_TO_FETCH=1: on the first clock edge after rst_n rises.
  - RESET_TO_FETCH=0: on a clock edge with start=1.
- FETCH: mem_read=1, adr_src=0, src_a=0, src_b=2, ADD, result_src=2.
  - ir_write=pc_write=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - mem_ready=1 on the first FETCH cycle gives a 1-cycle fetch.
- DECODE: src_a=1, src_b=1, ADD (branch target into ALUOut).
  - Opcode 0110011 → EXEC_R; 0010011 with f3=000 → EXEC_I.
  - 0000011/f3=010 or 0100011/f3=010 → MEM_ADDR.
  - 1100011/f3=001 → BRANCH.
  - Any other opcode or funct → TRAP.
- EXEC_R: src_a=2, src_b=0. Decode then → WB_ALU:
  - f3=000, f7=0000000 → ADD
  - f3=000, f7=0100000 → SUB
  - f3=100, f7=0 → XOR
  - f3=001, f7=0 → SLL
  - Any other f3/f7 in opcode 0110011 is caught in DECODE → TRAP.
- EXEC_I: src_a=2, src_b=1, ADD → WB_ALU.
- WB_ALU: result_src=0, reg_write=1 → FETCH.
- MEM_ADDR: src_a=2, src_b=1, ADD → MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_read=1, adr_src=1; stay until mem_ready → WB_MEM.
- WB_MEM: result_src=1, reg_write=1 → FETCH.
- MEM_WR: mem_write=1, adr_src=1; stay until mem_ready → FETCH.
- BRANCH: src_a=2, src_b=0, alu_ctrl=4, result_src=0, pc_write=~zero → FETCH.
- TRAP: illegal=1, all other outputs 0; remain until reset.
- Request outputs (mem_read, mem_write, adr_src) are stable while waiting.
- mem_ready outside MEM states or FETCH is ignored.
- Reset mid-wait drops the request immediately (async).
- CPI: R/I 4, BNE 3, SW 4, LW 5, each assuming zero-wait memory.

Optional Feature:
- RV_CTRL_INSTRET_EN defined:
  - instret increments by 1 on every transition into FETCH from WB_ALU, WB_MEM, MEM_WR or BRANCH.
  - Wraps 0xFFFFFFFF → 0. Reset to 0.
  - Does not count RESET→FETCH.
- Undefined: instret tied to 0; no counter flops.

Decomposition:
- Package riscv_ctrl_pkg:
  - opcode constants; funct3/funct7 constants
  - ALU code constants 0..4
  - state enum (RESET, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, TRAP)
  - src_a/src_b/result_src encodings
- Sub-module riscv_alu_dec:
  - Combinational funct3/funct7 → alu_ctrl plus legal bit.
  - Reused by DECODE legality check and EXEC_R.

Test Plan:
- rst_n low then high, instr=0x00208033 (add x0,x1,x2), mem_ready=1 → RESET, FETCH(ir_write,pc_write=1), DECODE, EXEC_R(alu_ctrl=0), WB_ALU(reg_write=1), FETCH; instret=1 when enabled.
- instr=0x4020_8033 (sub), then 0x0020_C033 (xor), then 0x0020_9033 (sll) → alu_ctrl 1, 2, 3 in EXEC_R.
- instr=0x0000_A083 (lw), mem_ready held low 3 cycles in MEM_RD → mem_read=1, adr_src=1 stable for 3 cycles; WB_MEM result_src=1, reg_write=1.
- instr=0x0020_9463 (bne): zero=0 → BRANCH pc_write=1; repeat with zero=1 → pc_write=0; alu_ctrl=4 in both.
- instr=0x0000_0073 → DECODE→TRAP; illegal=1 held for 10 cycles despite mem_ready toggling; rst_n low clears it to 0.
- rst_n asserted mid MEM_WR wait → mem_write drops to 0 in the same cycle; state RESET.
